// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Package : keypad_pkg
// Brief   : Shared state type, idle row pattern and decode helpers for the
//           matrix keypad scanner.
// Rev     : 1.0
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic logic [3:0] onehot_low(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    // Returns {valid_single, idx}; valid only when exactly one row is pulled low.
    function automatic logic [2:0] row_index(input logic [3:0] rows);
        logic [2:0] res;
        case (rows)
            4'b1110: res = 3'b1_00;
            4'b1101: res = 3'b1_01;
            4'b1011: res = 3'b1_10;
            4'b0111: res = 3'b1_11;
            default: res = 3'b0_00;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module : keypad_sync
// Brief  : Two-flop synchronizer; resets to all-ones (idle pulled-up rows).
// Rev    : 1.0
// ============================================================================
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module : keypad_scanner
// Brief  : 4x4 matrix keypad scan with press/release debounce and key strobe.
//          Define KEYPAD_REPEAT_EN to add auto-repeat strobes while held.
// Rev    : 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter logic [7:0]  DEBOUNCE_CNT   = 8'd4,
    parameter logic [15:0] REPEAT_SAMPLES = 16'd200
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [3:0] i_rows,
    output logic [3:0] o_cols,
    output logic [3:0] o_key,
    output logic       o_key_valid,
    output logic       o_key_held
);

    kp_state_t   state_q, state_d;
    logic [15:0] step_q,  step_d;
    logic [1:0]  col_q,   col_d;
    logic [3:0]  pat_q,   pat_d;
    logic [7:0]  deb_q,   deb_d;
    logic [3:0]  key_q,   key_d;
    logic        valid_q, valid_d;
    logic        held_q,  held_d;

    logic [3:0]  w_sample;
    logic        w_sample_en;
    logic [2:0]  w_row_sel;

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rep_q, rep_d;
`else
    localparam logic [15:0] c_unused_repeat_samples = REPEAT_SAMPLES;
`endif

    keypad_sync #(
        .WIDTH (4)
    ) u_sync (
        .clk_i   (i_clock),
        .rst_ni  (i_reset_n),
        .async_i (i_rows),
        .sync_o  (w_sample)
    );

    // Rows are only acted on during the last cycle of each column step.
    assign w_sample_en = (step_q == SCAN_DIV - 16'd1);
    assign step_d      = w_sample_en ? 16'd0 : step_q + 16'd1;
    assign w_row_sel   = row_index(w_sample);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        pat_d   = pat_q;
        deb_d   = deb_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (w_sample_en) begin
            case (state_q)
                SCAN: begin
                    if (w_row_sel[2]) begin
                        pat_d = w_sample;
                        deb_d = 8'd1;
                        if (DEBOUNCE_CNT <= 8'd1) begin
                            state_d = PRESSED;
                            key_d   = {w_row_sel[1:0], col_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = 16'd0;
`endif
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        // Idle or multi-row (ghost) sample: keep scanning.
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_sample == pat_q) begin
                        if (deb_q + 8'd1 >= DEBOUNCE_CNT) begin
                            state_d = PRESSED;
                            key_d   = {w_row_sel[1:0], col_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = 16'd0;
`endif
                        end else begin
                            deb_d = deb_q + 8'd1;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                PRESSED: begin
                    if (w_sample == ROWS_IDLE) begin
                        if (DEBOUNCE_CNT <= 8'd1) begin
                            state_d = SCAN;
                            held_d  = 1'b0;
                            col_d   = col_q + 2'd1;
                        end else begin
                            state_d = RELEASE;
                            deb_d   = 8'd1;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_q + 16'd1 >= REPEAT_SAMPLES) begin
                        valid_d = 1'b1;
                        rep_d   = 16'd0;
                    end else begin
                        rep_d = rep_q + 16'd1;
                    end
`endif
                end
                RELEASE: begin
                    if (w_sample == ROWS_IDLE) begin
                        if (deb_q + 8'd1 >= DEBOUNCE_CNT) begin
                            state_d = SCAN;
                            held_d  = 1'b0;
                            col_d   = col_q + 2'd1;
                        end else begin
                            deb_d = deb_q + 8'd1;
                        end
                    end else begin
                        state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = 16'd0;
`endif
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= SCAN;
            step_q  <= 16'd0;
            col_q   <= 2'd0;
            pat_q   <= ROWS_IDLE;
            deb_q   <= 8'd0;
            key_q   <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
            deb_q   <= deb_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign o_cols      = onehot_low(col_q);
    assign o_key       = key_q;
    assign o_key_valid = valid_q;
    assign o_key_held  = held_q;

endmodule
`default_nettype wire
